// File: rtl/sweep_sequencer_if.sv
// Handshake and result-buffer bus between the sweep sequencer and its environment
// (PLL sweeper, RAM tester and result reader).
interface sweep_sequencer_if #(
  parameter int DEPTH_LOG2 = 6,
  parameter int FAIL_W     = 16
);
  logic                  run;
  logic                  freq_ready;
  logic [8:0]            frequency;
  logic                  next_frequency;
  logic                  test_start;
  logic                  test_done;
  logic [FAIL_W-1:0]     test_fail_count;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [8:0]            rd_freq;
  logic [FAIL_W-1:0]     rd_fails;
  logic [DEPTH_LOG2:0]   entries;
  logic                  busy;
  logic                  sweep_done;
  logic                  timeout_seen;

  // Sequencer side
  modport master (
    input  run, freq_ready, frequency, test_done, test_fail_count, rd_addr,
    output next_frequency, test_start, rd_freq, rd_fails, entries, busy,
           sweep_done, timeout_seen
  );

  // Environment side
  modport slave (
    output run, freq_ready, frequency, test_done, test_fail_count, rd_addr,
    input  next_frequency, test_start, rd_freq, rd_fails, entries, busy,
           sweep_done, timeout_seen
  );
endinterface

// File: rtl/sweep_sequencer.sv
// Frequency sweep sequencer: waits for a settled PLL, runs one RAM test pass,
// logs {frequency, failures}, then steps the sweeper until the sweep ends.
module sweep_sequencer #(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FREQ_MAX       = 400,
  parameter int DEPTH_LOG2     = 6,
  parameter int FAIL_W         = 16
) (
  input  logic         CLK_50,
  input  logic         reset,
  sweep_sequencer_if.master bus
);

  localparam int PH_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW     = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    IDLE, SETTLE, START, TEST, STORE, PULSE, RELEASE, DONE
  } state_t;

  typedef struct packed {
    logic [8:0]        freq;
    logic [FAIL_W-1:0] fails;
  } entry_t;

  state_t            state, nxt;
  logic [15:0]       settle_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [PH_W-1:0]   ph_cnt;
  logic [8:0]        freq_cap;
  logic [FAIL_W-1:0] fail_cap;
  logic [EW-1:0]     entries_q, entries_inc;
  logic              timeout_q;
  logic              nf_q, ts_q, busy_q, done_q;
  logic              nf_d, ts_d, busy_d, done_d;
  logic              settle_hit, to_hit, pulse_hit, hold_hit, stop;
  entry_t            mem [0:(1<<DEPTH_LOG2)-1];
  entry_t            rd_q;

  assign settle_hit  = (settle_cnt == 16'(SETTLE_CYCLES - 1));
  assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign pulse_hit   = (ph_cnt == PH_W'(PULSE_CYCLES - 1));
  assign hold_hit    = (ph_cnt == PH_W'(HOLDOFF_CYCLES - 1));
  assign entries_inc = entries_q + EW'(1);
  // End of sweep: top frequency reached or the entry just written fills the buffer.
  assign stop        = (freq_cap >= 9'(FREQ_MAX)) || (entries_inc == EW'(1 << DEPTH_LOG2));

  // State register
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.run) nxt = SETTLE;
      SETTLE:  if (bus.freq_ready && settle_hit) nxt = START;
      START:   nxt = TEST;
      TEST:    if (bus.test_done || to_hit) nxt = STORE;
      STORE:   nxt = stop ? DONE : PULSE;
      PULSE:   if (pulse_hit) nxt = RELEASE;
      RELEASE: if (hold_hit) nxt = SETTLE;
      DONE:    if (!bus.run) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    nf_d   = (nxt == PULSE);
    ts_d   = (nxt == START);
    busy_d = (nxt != IDLE) && (nxt != DONE);
    done_d = (nxt == DONE);
  end

  // Registered outputs; reset drops next_frequency immediately
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      nf_q   <= 1'b0;
      ts_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      nf_q   <= nf_d;
      ts_q   <= ts_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Counters, captures, entry count and sticky timeout flag
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
      to_cnt     <= '0;
      ph_cnt     <= '0;
      freq_cap   <= '0;
      fail_cap   <= '0;
      entries_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // Settle counter only runs in SETTLE, so every entry starts from zero
      if (state == SETTLE && bus.freq_ready) settle_cnt <= settle_cnt + 16'd1;
      else                                   settle_cnt <= '0;
      to_cnt <= (state == TEST) ? to_cnt + TO_W'(1) : '0;
      if (state == nxt && (state == PULSE || state == RELEASE)) ph_cnt <= ph_cnt + PH_W'(1);
      else                                                      ph_cnt <= '0;
      if (state == SETTLE && nxt == START) freq_cap <= bus.frequency;
      if (state == IDLE && bus.run) begin
        entries_q <= '0;
        timeout_q <= 1'b0;
      end
      // test_done has priority over a timeout in the same cycle
      if (state == TEST) begin
        if (bus.test_done) fail_cap <= bus.test_fail_count;
        else if (to_hit) begin
          fail_cap  <= '1;
          timeout_q <= 1'b1;
        end
      end
      if (state == STORE) entries_q <= entries_inc;
    end
  end

  // Result buffer write; contents are not reset
  always_ff @(posedge CLK_50) begin
    if (state == STORE) mem[entries_q[DEPTH_LOG2-1:0]] <= '{freq: freq_cap, fails: fail_cap};
  end

  // Registered read port; same-address write in the same cycle returns old data
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= mem[bus.rd_addr];
  end

  assign bus.next_frequency = nf_q;
  assign bus.test_start     = ts_q;
  assign bus.busy           = busy_q;
  assign bus.sweep_done     = done_q;
  assign bus.entries        = entries_q;
  assign bus.timeout_seen   = timeout_q;
  assign bus.rd_freq        = rd_q.freq;
  assign bus.rd_fails       = rd_q.fails;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: a main instance (FREQ_MAX=110, 64 entries) and a
// small-buffer instance (4 entries, FREQ_MAX=400). Stored entries are checked
// against a scoreboard queue filled when each test pass is answered.
module tb_sweep_sequencer;
  localparam int LIMIT = 300;

  typedef struct {
    logic [8:0]  f;
    logic [15:0] c;
  } exp_t;

  logic CLK_50 = 1'b0;
  logic reset  = 1'b1;
  always #5 CLK_50 = ~CLK_50;

  sweep_sequencer_if #(.DEPTH_LOG2(6), .FAIL_W(16)) b();
  sweep_sequencer_if #(.DEPTH_LOG2(2), .FAIL_W(16)) b2();

  sweep_sequencer #(.SETTLE_CYCLES(4), .HOLDOFF_CYCLES(8), .PULSE_CYCLES(4),
                    .TIMEOUT_CYCLES(50), .FREQ_MAX(110), .DEPTH_LOG2(6), .FAIL_W(16))
    u (.CLK_50(CLK_50), .reset(reset), .bus(b.master));

  sweep_sequencer #(.SETTLE_CYCLES(4), .HOLDOFF_CYCLES(8), .PULSE_CYCLES(4),
                    .TIMEOUT_CYCLES(50), .FREQ_MAX(400), .DEPTH_LOG2(2), .FAIL_W(16))
    u2 (.CLK_50(CLK_50), .reset(reset), .bus(b2.master));

  int   tests = 0, fails = 0;
  exp_t sb[$];
  exp_t log_q[$];

  // next_frequency pulse-width monitor for the main instance
  int nf_run = 0, nf_last = 0, nf_pulses = 0;
  always @(negedge CLK_50) begin
    if (b.next_frequency) nf_run++;
    else if (nf_run != 0) begin
      nf_last = nf_run;
      nf_run  = 0;
      nf_pulses++;
    end
  end

  task automatic tick();
    @(negedge CLK_50);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin tick(); n++; end while (!b.test_start && n < LIMIT);
  endtask

  task automatic wait_entries(input int from, output int n);
    n = 0;
    do begin tick(); n++; end while (int'(b.entries) == from && n < LIMIT);
  endtask

  task automatic wait_nf_fall(output int n);
    n = 0;
    while (b.next_frequency && n < LIMIT) begin tick(); n++; end
  endtask

  task automatic read_entry(input int a, output logic [8:0] f, output logic [15:0] c);
    b.rd_addr = a[5:0];
    tick();
    f = b.rd_freq;
    c = b.rd_fails;
  endtask

  task automatic answer(input logic [8:0] f, input logic [15:0] c);
    sb.push_back('{f: f, c: c});
    log_q.push_back('{f: f, c: c});
    b.test_fail_count = c;
    b.test_done = 1'b1;
    tick();
    b.test_done = 1'b0;
  endtask

  task automatic test_reset();
    b.run = 0; b.freq_ready = 0; b.frequency = 0; b.test_done = 0; b.test_fail_count = 0; b.rd_addr = 0;
    b2.run = 0; b2.freq_ready = 0; b2.frequency = 0; b2.test_done = 0; b2.test_fail_count = 0; b2.rd_addr = 0;
    reset = 1'b1;
    tick(); tick();
    tests++;
    if ({b.next_frequency, b.test_start, b.busy, b.sweep_done, b.timeout_seen} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got=%b exp=00000",
        {b.next_frequency, b.test_start, b.busy, b.sweep_done, b.timeout_seen});
    end
    tests++;
    if ({b.entries, b.rd_freq, b.rd_fails} !== '0) begin
      fails++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0", b.entries, b.rd_freq, b.rd_fails);
    end
    tests++;
    if ({b2.busy, b2.sweep_done, b2.entries} !== '0) begin
      fails++; $display("FAIL reset_u2 got=%b/%b/%0d exp=0", b2.busy, b2.sweep_done, b2.entries);
    end
    reset = 1'b0;
    tick(); tick();
    tests++;
    if (b.busy !== 1'b0) begin fails++; $display("FAIL idle_no_run got=%b exp=0", b.busy); end
  endtask

  task automatic test_basic();
    int n; exp_t e; logic [8:0] f; logic [15:0] c;
    b.frequency = 100; b.freq_ready = 1; b.run = 1;
    tick();
    tests++;
    if (b.busy !== 1'b1) begin fails++; $display("FAIL busy_on_run got=%b exp=1", b.busy); end
    wait_start(n);
    tests++;
    if (n != 4) begin fails++; $display("FAIL basic_start_latency got=%0d exp=4", n); end
    tick();
    tests++;
    if (b.test_start !== 1'b0) begin fails++; $display("FAIL start_one_cycle got=%b exp=0", b.test_start); end
    tick(); tick();
    answer(9'd100, 16'd7);
    wait_entries(0, n);
    tests++;
    if (n != 1 || b.next_frequency !== 1'b1) begin
      fails++; $display("FAIL basic_store got=%0d/%b exp=1/1", n, b.next_frequency);
    end
    e = sb.pop_front();
    read_entry(int'(b.entries) - 1, f, c);
    tests++;
    if ({f, c} !== {e.f, e.c} || b.entries !== 7'd1) begin
      fails++; $display("FAIL basic_entry got=%0d/%0d n=%0d exp=%0d/%0d n=1", f, c, b.entries, e.f, e.c);
    end
  endtask

  task automatic test_settle_glitch();
    int n; exp_t e; logic [8:0] f; logic [15:0] c;
    b.freq_ready = 0; b.frequency = 105;
    wait_nf_fall(n);
    tests++;
    if (n != 3) begin fails++; $display("FAIL nf_fall got=%0d exp=3", n); end
    repeat (12) tick();
    tests++;
    if (nf_last != 4) begin fails++; $display("FAIL pulse_width got=%0d exp=4", nf_last); end
    tests++;
    if (b.test_start !== 1'b0 || b.busy !== 1'b1) begin
      fails++; $display("FAIL settle_wait got=%b/%b exp=0/1", b.test_start, b.busy);
    end
    b.freq_ready = 1; tick(); tick();
    b.freq_ready = 0; tick();
    b.freq_ready = 1;
    wait_start(n);
    tests++;
    if (n != 4) begin fails++; $display("FAIL glitch_restart got=%0d exp=4", n); end
    tick();
    answer(9'd105, 16'd3);
    wait_entries(1, n);
    e = sb.pop_front();
    read_entry(int'(b.entries) - 1, f, c);
    tests++;
    if ({f, c} !== {e.f, e.c}) begin fails++; $display("FAIL glitch_entry got=%0d/%0d exp=%0d/%0d", f, c, e.f, e.c); end
  endtask

  task automatic test_stale_ready_done_at_limit();
    int n; exp_t e; logic [8:0] f; logic [15:0] c;
    b.frequency = 106;
    wait_nf_fall(n);
    wait_start(n);
    tests++;
    if (n != 12) begin fails++; $display("FAIL stale_ready got=%0d exp=12", n); end
    // test_done lands in the last TEST cycle before the timeout would fire
    repeat (50) tick();
    answer(9'd106, 16'd21);
    wait_entries(2, n);
    tests++;
    if (n != 1 || b.timeout_seen !== 1'b0) begin
      fails++; $display("FAIL done_wins got=%0d/%b exp=1/0", n, b.timeout_seen);
    end
    e = sb.pop_front();
    read_entry(int'(b.entries) - 1, f, c);
    tests++;
    if ({f, c} !== {e.f, e.c}) begin fails++; $display("FAIL limit_entry got=%0d/%0d exp=%0d/%0d", f, c, e.f, e.c); end
  endtask

  task automatic test_timeout();
    int n; exp_t e; logic [8:0] f; logic [15:0] c;
    b.frequency = 108;
    wait_nf_fall(n);
    wait_start(n);
    sb.push_back('{f: 9'd108, c: 16'hFFFF});
    log_q.push_back('{f: 9'd108, c: 16'hFFFF});
    wait_entries(3, n);
    tests++;
    if (n != 52) begin fails++; $display("FAIL timeout_latency got=%0d exp=52", n); end
    tests++;
    if (b.timeout_seen !== 1'b1 || b.next_frequency !== 1'b1) begin
      fails++; $display("FAIL timeout_flags got=%b/%b exp=1/1", b.timeout_seen, b.next_frequency);
    end
    e = sb.pop_front();
    read_entry(int'(b.entries) - 1, f, c);
    tests++;
    if ({f, c} !== {e.f, e.c}) begin fails++; $display("FAIL timeout_entry got=%0d/%0h exp=%0d/%0h", f, c, e.f, e.c); end
  endtask

  task automatic test_freq_max();
    int n, p0; exp_t e; logic [8:0] f; logic [15:0] c;
    b.frequency = 110;
    wait_nf_fall(n);
    wait_start(n);
    tick();
    answer(9'd110, 16'd9);
    wait_entries(4, n);
    tests++;
    if ({b.sweep_done, b.busy, b.next_frequency} !== 3'b100 || b.entries !== 7'd5) begin
      fails++; $display("FAIL freq_max_stop got=%b%b%b n=%0d exp=100 n=5",
        b.sweep_done, b.busy, b.next_frequency, b.entries);
    end
    e = sb.pop_front();
    read_entry(int'(b.entries) - 1, f, c);
    tests++;
    if ({f, c} !== {e.f, e.c}) begin fails++; $display("FAIL last_entry got=%0d/%0d exp=%0d/%0d", f, c, e.f, e.c); end
    p0 = nf_pulses;
    repeat (20) tick();
    tests++;
    if (nf_pulses != p0 || nf_run != 0 || b.sweep_done !== 1'b1) begin
      fails++; $display("FAIL done_hold got=%0d/%0d/%b exp=%0d/0/1", nf_pulses, nf_run, b.sweep_done, p0);
    end
  endtask

  task automatic test_readback();
    exp_t prev;
    prev = log_q[4];
    for (int a = 0; a < 3; a++) begin
      b.rd_addr = a[5:0];
      #1;
      tests++;
      if ({b.rd_freq, b.rd_fails} !== {prev.f, prev.c}) begin
        fails++; $display("FAIL rd_latency a=%0d got=%0d/%0d exp=%0d/%0d", a, b.rd_freq, b.rd_fails, prev.f, prev.c);
      end
      tick();
      tests++;
      if ({b.rd_freq, b.rd_fails} !== {log_q[a].f, log_q[a].c}) begin
        fails++; $display("FAIL rd_data a=%0d got=%0d/%0d exp=%0d/%0d", a, b.rd_freq, b.rd_fails, log_q[a].f, log_q[a].c);
      end
      prev = log_q[a];
    end
    b.run = 0;
    tick();
    tests++;
    if (b.sweep_done !== 1'b0 || b.busy !== 1'b0 || b.entries !== 7'd5) begin
      fails++; $display("FAIL idle_retain got=%b/%b/%0d exp=0/0/5", b.sweep_done, b.busy, b.entries);
    end
  endtask

  task automatic test_depth_full();
    int k; exp_t e;
    b2.freq_ready = 1; b2.frequency = 200; b2.run = 1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      do begin tick(); k++; end while (!b2.test_start && k < LIMIT);
      tests++;
      if (k != ((i == 0) ? 5 : 16)) begin
        fails++; $display("FAIL step_latency i=%0d got=%0d exp=%0d", i, k, (i == 0) ? 5 : 16);
      end
      tick();
      sb.push_back('{f: 9'(200 + i), c: 16'(40 + i)});
      b2.test_fail_count = 16'(40 + i); b2.test_done = 1; tick(); b2.test_done = 0;
      k = 0;
      do begin tick(); k++; end while (int'(b2.entries) == i && k < LIMIT);
      b2.frequency = 9'(201 + i);
    end
    tests++;
    if (b2.entries !== 3'd4 || b2.sweep_done !== 1'b1 || b2.next_frequency !== 1'b0) begin
      fails++; $display("FAIL depth_full got=%0d/%b/%b exp=4/1/0", b2.entries, b2.sweep_done, b2.next_frequency);
    end
    for (int a = 0; a < 4; a++) begin
      b2.rd_addr = a[1:0];
      tick();
      e = sb.pop_front();
      tests++;
      if ({b2.rd_freq, b2.rd_fails} !== {e.f, e.c}) begin
        fails++; $display("FAIL depth_entry a=%0d got=%0d/%0d exp=%0d/%0d", a, b2.rd_freq, b2.rd_fails, e.f, e.c);
      end
    end
    b2.run = 0;
  endtask

  task automatic test_reset_mid_pulse();
    int n; exp_t e; logic [8:0] f; logic [15:0] c;
    b.frequency = 100; b.freq_ready = 1; b.run = 1;
    tick();
    tests++;
    if (b.entries !== 7'd0 || b.timeout_seen !== 1'b0) begin
      fails++; $display("FAIL rerun_clear got=%0d/%b exp=0/0", b.entries, b.timeout_seen);
    end
    wait_start(n);
    tick();
    answer(9'd100, 16'd5);
    wait_entries(0, n);
    e = sb.pop_front();
    read_entry(0, f, c);
    tests++;
    if ({f, c} !== {e.f, e.c}) begin fails++; $display("FAIL rerun_entry got=%0d/%0d exp=%0d/%0d", f, c, e.f, e.c); end
    tick();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (b.next_frequency !== 1'b0 || b.entries !== 7'd0 || b.busy !== 1'b0) begin
      fails++; $display("FAIL async_reset got=%b/%0d/%b exp=0/0/0", b.next_frequency, b.entries, b.busy);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    wait_start(n);
    tests++;
    if (n != 4) begin fails++; $display("FAIL restart_latency got=%0d exp=4", n); end
    tick();
    answer(9'd100, 16'd11);
    wait_entries(0, n);
    e = sb.pop_front();
    read_entry(0, f, c);
    tests++;
    if ({f, c} !== {e.f, e.c} || b.entries !== 7'd1) begin
      fails++; $display("FAIL restart_entry got=%0d/%0d n=%0d exp=%0d/%0d n=1", f, c, b.entries, e.f, e.c);
    end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_settle_glitch();
    test_stale_ready_done_at_limit();
    test_timeout();
    test_freq_max();
    test_readback();
    test_depth_full();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
Sits directly downstream of the PLL reconfiguration sweeper and drives it. It waits for a stable `freq_ready`, starts one RAM test pass at that frequency, and logs the frequency/failure pair in a result buffer. It then pulses `next_frequency` high then low to step the sweeper, and repeats until a frequency limit or buffer-full stops the sweep. All logic runs in the CLK_50 domain; the RAM tester's start/done handshake is already synchronised into CLK_50.

Parameters:
SETTLE_CYCLES, 1024, consecutive cycles `freq_ready` must stay high before a test starts (min 1)
HOLDOFF_CYCLES, 8, blanking cycles after `next_frequency` release during which `freq_ready` is ignored
PULSE_CYCLES, 4, cycles `next_frequency` is held high (min 1)
TIMEOUT_CYCLES, 1000000, max cycles from `test_start` to `test_done`
FREQ_MAX, 400, sweep stops after storing an entry with captured frequency >= FREQ_MAX
DEPTH_LOG2, 6, result buffer depth is 2^DEPTH_LOG2 entries
FAIL_W, 16, failure-count width

Ports:
CLK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  level; sweep starts on IDLE with run=1
freq_ready  in  1  sweeper reports PLL locked and idle at current frequency
frequency  in  9  current sweep frequency from sweeper
next_frequency  out  1  step request to sweeper
test_start  out  1  one-cycle pulse starting a RAM test pass
test_done  in  1  one-cycle pulse, test pass finished
test_fail_count  in  FAIL_W  failure count, valid with test_done
rd_addr  in  DEPTH_LOG2  result buffer read address
rd_freq  out  9  stored frequency at rd_addr, registered
rd_fails  out  FAIL_W  stored failure count at rd_addr, registered
entries  out  DEPTH_LOG2+1  number of valid stored entries
busy  out  1  high in every state except IDLE and DONE
sweep_done  out  1  high in DONE
timeout_seen  out  1  sticky; a pass timed out this sweep

Behaviour:
- Reset (async assert, sync release): state=IDLE. next_frequency, test_start, sweep_done, busy, timeout_seen and entries = 0. rd_freq and rd_fails = 0. Buffer contents are undefined.
- Reset mid-operation aborts immediately. next_frequency drops asynchronously with no completion pulse.
- IDLE: if run=1, clear entries and timeout_seen, then go to SETTLE.
- SETTLE: 16-bit counter increments while freq_ready=1 and clears to 0 when freq_ready=0. When the counter reaches SETTLE_CYCLES-1 with freq_ready=1:
  - capture frequency into freq_cap;
  - go to START.
- START: test_start=1 for exactly one cycle. Clear the timeout counter. Go to TEST.
- TEST: wait for test_done.
  - On test_done: fail_cap <= test_fail_count, go to STORE.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 first: fail_cap <= all ones, timeout_seen <= 1, go to STORE.
  - test_done arriving in the same cycle as the timeout: test_done wins.
  - test_done outside TEST is ignored.
- STORE (1 cycle): write {freq_cap, fail_cap} at address entries[DEPTH_LOG2-1:0], entries <= entries+1. Then:
  - if freq_cap >= FREQ_MAX, or the new entries value = 2^DEPTH_LOG2, go to DONE;
  - otherwise go to PULSE.
- PULSE: next_frequency=1 for PULSE_CYCLES cycles, then go to RELEASE.
- RELEASE: next_frequency=0 for HOLDOFF_CYCLES cycles; freq_ready is ignored. Then go to SETTLE with the settle counter cleared. This rejects the stale freq_ready the sweeper can emit before it leaves its wait state.
- DONE: sweep_done=1, busy=0, next_frequency=0. Stay while run=1; go to IDLE when run=0. entries and buffer contents are retained in IDLE until the next run.
- run=0 in any busy state has no effect; the sweep completes.
- Read port: rd_freq and rd_fails update one cycle after rd_addr is sampled, independent of state.
  - Read-during-write to the same address returns the old data.
  - Addresses >= entries return undefined data.
- All outputs are registered. Total step latency (store to next SETTLE) = 1 + PULSE_CYCLES + HOLDOFF_CYCLES cycles.

Test Plan:
1. Basic pass. SETTLE_CYCLES=4, PULSE_CYCLES=4, HOLDOFF_CYCLES=8. run=1, freq_ready=1, frequency=100. Expect test_start pulse exactly 4 cycles after SETTLE entry. test_done with count=7 three cycles later. Expect entry0 = {100, 7}, entries=1, then next_frequency high exactly 4 cycles.
2. Settle glitch. freq_ready drops for 1 cycle at settle count 2 -> counter restarts; test_start appears 4 cycles after freq_ready returns high.
3. Stale ready. freq_ready=1 throughout RELEASE -> no test_start until HOLDOFF_CYCLES + SETTLE_CYCLES after next_frequency falls.
4. Timeout. TIMEOUT_CYCLES=50, test_done never asserted -> entry fails=16'hFFFF, timeout_seen=1, and the sweep continues to PULSE. test_done coincident with cycle 49 -> real count stored, timeout_seen stays 0.
5. Termination, FREQ_MAX=110. Sweep frequencies 100, 105, 110 -> entries=3, sweep_done=1, and no pulse after the third store. DEPTH_LOG2=2 with FREQ_MAX=400 -> stops at entries=4.
6. Reset mid-PULSE. Assert reset asynchronously -> next_frequency=0 in the same cycle, entries=0, state IDLE. After release with run=1, the sweep restarts cleanly. Readback of rd_addr 0..2 after test 5 returns the logged values with 1-cycle latency.
